// File: rtl/ssd1309_sequencer.sv
// SSD1309 128x64 OLED sequencer: RES pulse, init command stream, and full-frame push from a sync-read framebuffer.
// Optional feature: define SSD1309_AUTO_REFRESH_EN to stream frames continuously without start_frame.
module ssd1309_sequencer #(
    parameter int RES_LOW_CYCLES  = 270,
    parameter int RES_WAIT_CYCLES = 2700,
    parameter int FB_BYTES        = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_frame,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       oled_res,
    output logic       fb_rd_en,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] state_dbg
);

    // Byte handshake: a byte moves on any cycle with tx_valid && tx_ready; once tx_valid
    // rises, tx_valid/tx_byte/tx_dc hold until that transfer, and tx_valid is never withdrawn.

    typedef enum logic [3:0] {
        S_RES_LOW  = 4'd0,
        S_RES_WAIT = 4'd1,
        S_INIT     = 4'd2,
        S_IDLE     = 4'd3,
        S_WINDOW   = 4'd4,
        S_FETCH    = 4'd5,
        S_LOAD     = 4'd6,
        S_SEND     = 4'd7,
        S_DONE     = 4'd8
    } state_e;

    localparam int CNT_MAX = (RES_WAIT_CYCLES > RES_LOW_CYCLES) ? RES_WAIT_CYCLES : RES_LOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 1);
    localparam logic [9:0]       ADDR_LAST = 10'(FB_BYTES - 1);
    localparam logic [4:0]       INIT_LAST = 5'd22;
    localparam logic [4:0]       WIN_LAST  = 5'd5;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       idx_q, idx_d;
    logic [9:0]       addr_q, addr_d;
    logic [7:0]       pix_q, pix_d;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'hD5;
            5'd2:    b = 8'h80;
            5'd3:    b = 8'hA8;
            5'd4:    b = 8'h3F;
            5'd5:    b = 8'hD3;
            5'd6:    b = 8'h00;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'hA1;
            5'd9:    b = 8'hC8;
            5'd10:   b = 8'hDA;
            5'd11:   b = 8'h12;
            5'd12:   b = 8'h81;
            5'd13:   b = 8'h7F;
            5'd14:   b = 8'hD9;
            5'd15:   b = 8'hF1;
            5'd16:   b = 8'hDB;
            5'd17:   b = 8'h34;
            5'd18:   b = 8'hA4;
            5'd19:   b = 8'hA6;
            5'd20:   b = 8'h20;
            5'd21:   b = 8'h00;
            5'd22:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Column window 0..127, page window 0..7: the whole panel in horizontal addressing.
    function automatic logic [7:0] win_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'h21;
            5'd1:    b = 8'h00;
            5'd2:    b = 8'h7F;
            5'd3:    b = 8'h22;
            5'd4:    b = 8'h00;
            5'd5:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // The reset-timing counter saturates so a stuck state can never wrap it back into range.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        pix_d      = pix_q;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        tx_dc      = 1'b0;
        fb_rd_en   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_RES_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d = S_RES_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RES_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_INIT: begin
                tx_valid = 1'b1;
                tx_byte  = init_byte(idx_q);
                if (tx_ready) begin
                    if (idx_q == INIT_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                idx_d = '0;
`ifdef SSD1309_AUTO_REFRESH_EN
                state_d = S_WINDOW;
`else
                if (start_frame) begin
                    state_d = S_WINDOW;
                end
`endif
            end
            S_WINDOW: begin
                tx_valid = 1'b1;
                tx_byte  = win_byte(idx_q);
                if (tx_ready) begin
                    if (idx_q == WIN_LAST) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                        addr_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                fb_rd_en = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                pix_d   = fb_data;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = pix_q;
                tx_dc    = 1'b1;
                if (tx_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            // Separate pulse state keeps IDLE (and start_frame acceptance) one cycle after frame_done.
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_RES_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RES_LOW;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
        end
    end

    assign oled_res  = (state_q != S_RES_LOW);
    assign fb_addr   = addr_q;
    assign state_dbg = state_q;
`ifdef SSD1309_AUTO_REFRESH_EN
    assign busy = 1'b1;
`else
    assign busy = (state_q != S_IDLE);
`endif

endmodule
